// File: rtl/fft5_frame_ctrl_if.sv
// Sample stream into the FFT5 frame controller.
// The controller holds the slave side; the sample source is the master.
interface fft5_frame_ctrl_if #(
    parameter int WIDTH = 18
);
    logic             s_valid;
    logic [WIDTH-1:0] s_re;
    logic [WIDTH-1:0] s_im;
    logic             s_ready;

    modport master (
        output s_valid,
        output s_re,
        output s_im,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_re,
        input  s_im,
        output s_ready
    );
endinterface

// File: rtl/fft5_frame_ctrl.sv
// Frame sequencer for a 5/25-point FFT5 core: loads N samples,
// waits for N outputs under a watchdog, then pulses frame_done.
module fft5_frame_ctrl #(
    parameter int WIDTH   = 18,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic             cfg_size,
    output logic             cfg_ready,
    fft5_frame_ctrl_if.slave s,
    output logic [1:0]       fft_stages,
    output logic             fft_di_en,
    output logic [WIDTH-1:0] fft_di_re,
    output logic [WIDTH-1:0] fft_di_im,
    input  logic             fft_do_en,
    output logic             busy,
    output logic             frame_done,
    output logic             err_timeout,
    input  logic             err_clr
);
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, LOAD, DRAIN, DONE, ERR
    } state_t;

    state_t         state;
    logic [4:0]     n_len;
    logic [4:0]     in_cnt;
    logic [4:0]     out_cnt;
    logic [4:0]     out_nxt;
    logic [WDW-1:0] wdog;
    logic           s_ready_q;
    logic           take;
    logic           last_in;

    assign s.s_ready = s_ready_q;
    assign take      = (state == LOAD) & s.s_valid & s_ready_q;
    assign last_in   = (in_cnt == n_len - 5'd1);

    // Output count saturates at N so surplus do_en pulses are ignored
    always_comb begin
        out_nxt = out_cnt;
        if ((state == LOAD || state == DRAIN) && fft_do_en
            && out_cnt != n_len)
            out_nxt = out_cnt + 5'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            n_len       <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            wdog        <= '0;
            cfg_ready   <= 1'b1;
            s_ready_q   <= 1'b0;
            fft_stages  <= 2'd0;
            fft_di_en   <= 1'b0;
            fft_di_re   <= '0;
            fft_di_im   <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            fft_di_en  <= take;
            frame_done <= 1'b0;
            out_cnt    <= out_nxt;
            if (take) begin
                fft_di_re <= s.s_re;
                fft_di_im <= s.s_im;
            end
            unique case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        n_len      <= cfg_size ? 5'd25 : 5'd5;
                        fft_stages <= cfg_size ? 2'd2 : 2'd1;
                        cfg_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    s_ready_q <= 1'b1;
                    state     <= LOAD;
                end
                LOAD: begin
                    if (take) begin
                        in_cnt <= in_cnt + 5'd1;
                        if (last_in) begin
                            s_ready_q <= 1'b0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_nxt == n_len) begin
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end else if (wdog == WDW'(TIMEOUT - 1)) begin
                        fft_stages  <= 2'd0;
                        err_timeout <= 1'b1;
                        state       <= ERR;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                DONE: begin
                    in_cnt     <= '0;
                    out_cnt    <= '0;
                    wdog       <= '0;
                    fft_stages <= 2'd0;
                    busy       <= 1'b0;
                    cfg_ready  <= 1'b1;
                    state      <= IDLE;
                end
                ERR: begin
                    if (err_clr) begin
                        in_cnt      <= '0;
                        out_cnt     <= '0;
                        wdog        <= '0;
                        err_timeout <= 1'b0;
                        busy        <= 1'b0;
                        cfg_ready   <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft5_frame_ctrl.sv
// Bench for fft5_frame_ctrl: frames are planned as cycle timelines
// from which every per-cycle expected output is derived.
module tb_fft5_frame_ctrl;
    localparam int W    = 18;
    localparam int TMO  = 16;
    localparam int MAXC = 4096;

    logic         clk;
    logic         rst;
    logic         cfg_valid;
    logic         cfg_size;
    logic         cfg_ready;
    logic [1:0]   fft_stages;
    logic         fft_di_en;
    logic [W-1:0] fft_di_re;
    logic [W-1:0] fft_di_im;
    logic         fft_do_en;
    logic         busy;
    logic         frame_done;
    logic         err_timeout;
    logic         err_clr;

    fft5_frame_ctrl_if #(.WIDTH(W)) sif ();

    fft5_frame_ctrl #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_size(cfg_size),
        .cfg_ready(cfg_ready), .s(sif),
        .fft_stages(fft_stages), .fft_di_en(fft_di_en),
        .fft_di_re(fft_di_re), .fft_di_im(fft_di_im),
        .fft_do_en(fft_do_en), .busy(busy),
        .frame_done(frame_done), .err_timeout(err_timeout),
        .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stimulus per cycle
    bit           st_rst [MAXC];
    bit           st_cv  [MAXC];
    bit           st_cs  [MAXC];
    bit           st_sv  [MAXC];
    logic [W-1:0] st_re  [MAXC];
    logic [W-1:0] st_im  [MAXC];
    bit           st_do  [MAXC];
    bit           st_clr [MAXC];
    // expected per cycle
    bit           ex_busy [MAXC];
    logic [1:0]   ex_stg  [MAXC];
    bit           ex_srdy [MAXC];
    bit           ex_den  [MAXC];
    bit           ex_done [MAXC];
    bit           ex_err  [MAXC];
    bit           ex_chk  [MAXC];
    logic [W-1:0] ex_re   [MAXC];
    logic [W-1:0] ex_im   [MAXC];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit run    = 0;

    task automatic chk(input string nm, input int c,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s cycle=%0d got=%0h want=%0h",
                         nm, c, act, exp);
        end
    endtask

    // Plan one frame requested at cycle a. Timeline rules:
    // SETUP a+1, LOAD from a+2, DRAIN from the cycle after the
    // N-th accepted sample, DONE the cycle after N outputs are
    // seen in DRAIN, ERR after TMO DRAIN cycles without them.
    task automatic plan(input int a, input bit size,
                        input int vprob, input bit seqd,
                        input int npulse, input int pp,
                        input int clr_wait, input int rstk,
                        input bit hold_cfg, output int nxt);
        int n, code, c, k, tn, s, d, dd, e, cc, stop, last;
        int emitted;
        int tk [25];
        bit v, p, err;
        n    = size ? 25 : 5;
        code = size ? 2 : 1;
        dd   = 0;
        e    = 0;
        err  = 0;
        st_cv[a] = 1'b1;
        st_cs[a] = size;
        c = a + 2;
        k = 0;
        while (k < n) begin
            if (vprob < 0) v = ((c - a) % 2 == 0);
            else v = ($urandom_range(99) < vprob);
            st_sv[c] = v;
            if (v) begin
                if (seqd) begin
                    st_re[c] = W'(k + 1);
                    st_im[c] = W'(200 - k);
                end
                tk[k] = c;
                k++;
            end
            c++;
        end
        tn = tk[n-1];
        s  = tn + 1;
        emitted = 0;
        d = -1;
        c = a + 2;
        forever begin
            p = (emitted < npulse) && ($urandom_range(99) < pp);
            st_do[c] = p;
            if (p) begin
                emitted++;
                if (emitted == n) d = c;
            end
            if (c >= s && d >= 0) begin
                dd = c + 1;
                break;
            end
            if (c == s + TMO - 1) begin
                err = 1;
                e = c + 1;
                break;
            end
            c++;
        end
        if (err) begin
            cc = e + clr_wait;
            for (int i = e; i < cc; i++) st_clr[i] = 1'b0;
            st_clr[cc] = 1'b1;
            last = cc;
        end else begin
            last = dd;
        end
        stop = (rstk > 0) ? tk[rstk-1] + 1 : last;
        if (rstk > 0) st_rst[stop] = 1'b1;
        for (int i = a + 1; i <= stop; i++) begin
            st_cv[i]   = hold_cfg ? 1'b1 : ($urandom_range(3) == 0);
            st_cs[i]   = hold_cfg ? 1'b1 : 1'($urandom_range(1));
            ex_busy[i] = 1'b1;
            ex_stg[i]  = (err && i >= e) ? 2'd0 : 2'(code);
            ex_srdy[i] = (i >= a + 2 && i <= tn);
            ex_err[i]  = err && i >= e;
            ex_done[i] = !err && i == dd;
        end
        for (int j = 0; j < n; j++) begin
            if (tk[j] + 1 <= stop) begin
                ex_den[tk[j]+1] = 1'b1;
                ex_chk[tk[j]+1] = 1'b1;
                ex_re[tk[j]+1]  = st_re[tk[j]];
                ex_im[tk[j]+1]  = st_im[tk[j]];
            end
        end
        if (rstk > 0) begin
            ex_chk[stop+1] = 1'b1;
            ex_re[stop+1]  = '0;
            ex_im[stop+1]  = '0;
            nxt = stop + 1;
        end else begin
            nxt = last + 1;
        end
    endtask

    always @(negedge clk) begin
        if (run && cyc >= 1) begin
            chk("cfg_ready", cyc, cfg_ready, !ex_busy[cyc]);
            chk("s_ready", cyc, sif.s_ready, ex_srdy[cyc]);
            chk("fft_stages", cyc, fft_stages, ex_stg[cyc]);
            chk("fft_di_en", cyc, fft_di_en, ex_den[cyc]);
            chk("busy", cyc, busy, ex_busy[cyc]);
            chk("frame_done", cyc, frame_done, ex_done[cyc]);
            chk("err_timeout", cyc, err_timeout, ex_err[cyc]);
            chk("fft_di_re", cyc, fft_di_re, ex_re[cyc]);
            chk("fft_di_im", cyc, fft_di_im, ex_im[cyc]);
            // hand-derived timeline of the first two frames
            if (cyc == 4) chk("pin_stages5", cyc, fft_stages, 1);
            if (cyc == 10) chk("pin_last_re", cyc, fft_di_re, 5);
            if (cyc == 11) chk("pin_done5", cyc, frame_done, 1);
            if (cyc == 12) chk("pin_idle5", cyc, busy, 0);
            if (cyc == 35) chk("pin_pre_err", cyc, err_timeout, 0);
            if (cyc == 36) chk("pin_err", cyc, err_timeout, 1);
            if (cyc == 36) chk("pin_err_cfg", cyc, cfg_ready, 0);
            if (cyc == 40) chk("pin_clr", cyc, err_timeout, 0);
        end
    end

    initial begin
        int cur, gap, sz, n, np;
        logic [W-1:0] hr, hi;
        for (int c = 0; c < MAXC; c++) begin
            st_rst[c]  = 1'b0;
            st_cv[c]   = 1'b0;
            st_cs[c]   = 1'($urandom_range(1));
            st_sv[c]   = 1'($urandom_range(1));
            st_re[c]   = W'($urandom);
            st_im[c]   = W'($urandom);
            st_do[c]   = 1'($urandom_range(1));
            st_clr[c]  = ($urandom_range(7) == 0);
            ex_busy[c] = 1'b0;
            ex_stg[c]  = 2'd0;
            ex_srdy[c] = 1'b0;
            ex_den[c]  = 1'b0;
            ex_done[c] = 1'b0;
            ex_err[c]  = 1'b0;
            ex_chk[c]  = 1'b0;
            ex_re[c]   = '0;
            ex_im[c]   = '0;
        end
        for (int c = 0; c < 3; c++) begin
            st_rst[c] = 1'b1;
            ex_chk[c+1] = 1'b1;
        end
        plan(3, 0, 100, 1, 5, 100, 0, 0, 0, cur);
        plan(13, 0, 100, 1, 3, 100, 3, 0, 0, cur);
        plan(cur + 1, 1, -1, 0, 25, 50, 2, 0, 0, cur);
        plan(cur + 1, 1, 70, 0, 25, 60, 0, 12, 0, cur);
        plan(cur + 1, 0, 80, 0, 5, 90, 0, 0, 0, cur);
        plan(cur + 1, 0, 100, 0, 9, 100, 0, 0, 1, cur);
        plan(cur, 1, 100, 0, 29, 90, 0, 0, 0, cur);
        for (int f = 0; f < 12; f++) begin
            gap = $urandom_range(3);
            sz  = $urandom_range(1);
            n   = sz ? 25 : 5;
            np  = ($urandom_range(4) == 0) ? n - 1
                                          : n + $urandom_range(3);
            plan(cur + gap, 1'(sz), $urandom_range(100, 40), 0, np,
                 $urandom_range(100, 40), $urandom_range(4), 0, 0,
                 cur);
        end
        // data outputs hold between accepted samples
        hr = '0;
        hi = '0;
        for (int c = 1; c < MAXC; c++) begin
            if (ex_chk[c]) begin
                hr = ex_re[c];
                hi = ex_im[c];
            end else begin
                ex_re[c]  = hr;
                ex_im[c]  = hi;
                ex_chk[c] = 1'b1;
            end
        end
        run = 1'b1;
        for (int c = 0; c <= cur + 4; c++) begin
            cyc           = c;
            rst           = st_rst[c];
            cfg_valid     = st_cv[c];
            cfg_size      = st_cs[c];
            sif.s_valid   = st_sv[c];
            sif.s_re      = st_re[c];
            sif.s_im      = st_im[c];
            fft_do_en     = st_do[c];
            err_clr       = st_clr[c];
            @(posedge clk);
            #1;
        end
        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fft5_frame_ctrl.md
FFT5_FRAME_CTRL -- requirements
Module: fft5_frame_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports `clk` and `rst`, all state updated on the rising edge of `clk` only.
REQ-002 Parameter `WIDTH`, default 18: sample component width.
REQ-003 Parameter `TIMEOUT`, default 1024: maximum drain cycles before error.
REQ-004 `clk  in  1`: master clock.
REQ-005 `rst  in  1`: synchronous active-high reset.
REQ-006 `cfg_valid  in  1`: frame request present.
REQ-007 `cfg_size  in  1`: frame size, 0 = 5-point, 1 = 25-point.
REQ-008 `cfg_ready  out  1`: request accepted this cycle.
REQ-009 `s_valid  in  1`: upstream sample valid.
REQ-010 `s_re`, `s_im  in  WIDTH each`: upstream sample.
REQ-011 `s_ready  out  1`: controller accepts a sample.
REQ-012 `fft_stages  out  2`: FFT size select to FFT5, 1 = 5-point, 2 = 25-point, 0 = off.
REQ-013 `fft_di_en  out  1`: FFT input enable.
REQ-014 `fft_di_re`, `fft_di_im  out  WIDTH each`: FFT input data.
REQ-015 `fft_do_en  in  1`: FFT output enable, observed for counting.
REQ-016 `busy  out  1`: high in any state except IDLE.
REQ-017 `frame_done  out  1`: one-cycle pulse at frame completion.
REQ-018 `err_timeout  out  1`: sticky drain-timeout flag.
REQ-019 `err_clr  in  1`: clears the error and returns the block to IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, SETUP, LOAD, DRAIN, DONE and ERR.
REQ-021 IDLE SHALL behave as follows.
- `cfg_ready` = 1 and `fft_stages` = 0.
- `cfg_valid` = 1 latches N (5 or 25) and the matching stages code, then moves to SETUP.
REQ-022 SETUP SHALL last exactly 1 cycle.
- `fft_stages` is driven with the latched code; `s_ready` = 0 and `fft_di_en` = 0.
- This gives FFT5 one cycle to register its stage select.
- Then moves to LOAD.
REQ-023 LOAD SHALL behave as follows.
- `s_ready` = 1 while input count < N.
- Each cycle with `s_valid` & `s_ready` registers `s_re`/`s_im` onto `fft_di_re`/`fft_di_im` with `fft_di_en` = 1 the next cycle, then increments the input count.
- Otherwise `fft_di_en` = 0 and the data outputs hold.
REQ-024 Gaps in `s_valid` SHALL stall LOAD without a timeout.
REQ-025 When the N-th sample is accepted, the state SHALL move to DRAIN and `s_ready` SHALL deassert in the same cycle as the transition.
REQ-026 The output counter SHALL increment on every `fft_do_en` = 1 in LOAD and DRAIN.
- It saturates at N.
- Pulses beyond N are ignored.
REQ-027 DRAIN SHALL behave as follows.
- Output count == N moves to DONE.
- Otherwise a watchdog counts cycles in DRAIN; reaching `TIMEOUT` moves to ERR.
REQ-028 DONE SHALL last 1 cycle.
- `frame_done` = 1, `fft_stages` is still held, counters clear, then the state moves to IDLE.
REQ-029 `fft_stages` SHALL remain constant from SETUP through DONE.
- A `cfg_size` change outside IDLE has no effect.
REQ-030 ERR SHALL behave as follows.
- `err_timeout` = 1, `fft_stages` = 0, `s_ready` = 0, `cfg_ready` = 0.
- `err_clr` = 1 clears all counters and `err_timeout` and moves to IDLE next cycle.
- `err_clr` in any other state has no effect.
REQ-031 `cfg_valid` in the DONE cycle SHALL be accepted only in the following IDLE cycle, so back-to-back frames have a minimum 1-cycle IDLE gap.
REQ-032 Input and output counters SHALL be 5 bits wide; the watchdog counter SHALL be `$clog2(TIMEOUT+1)` bits wide.

Reset
REQ-033 `rst` = 1 at any clock edge, including mid-frame, SHALL return the block to IDLE on the next edge.
- All counters cleared.
- Outputs: `cfg_ready` = 1, `s_ready` = 0, `fft_stages` = 0, `fft_di_en` = 0, `fft_di_re` = `fft_di_im` = 0, `busy` = 0, `frame_done` = 0, `err_timeout` = 0.
REQ-034 `rst` SHALL take priority over `err_clr` and all other inputs.

Verification
REQ-035 5-point frame.
- Stimulus: `cfg_valid` with `cfg_size` = 0, 5 back-to-back samples 1..5; FFT model returns 5 `do_en` pulses.
- Response: `fft_stages` = 1 from SETUP to DONE; `fft_di_en` high for 5 cycles carrying 1..5; one `frame_done`; then IDLE.
REQ-036 25-point frame with `s_valid` gaps.
- Stimulus: 25 samples with `s_valid` toggling every other cycle.
- Response: exactly 25 `fft_di_en` pulses, order preserved; `fft_stages` = 2 throughout; `frame_done` after the 25th `do_en`.
REQ-037 Drain timeout.
- Stimulus: `TIMEOUT` = 16, 5-point frame, FFT returns only 3 `do_en` pulses.
- Response: ERR entered 16 cycles into DRAIN; `err_timeout` = 1; `cfg_ready` = 0.
- Then `err_clr` gives IDLE with `err_timeout` = 0.
REQ-038 Reset mid-LOAD.
- Stimulus: `rst` asserted after 12 of 25 samples.
- Response: next cycle `busy` = 0, `fft_stages` = 0, `s_ready` = 0.
- A subsequent 5-point frame completes normally.
REQ-039 Back-to-back requests.
- Stimulus: `cfg_valid` held high with sizes 0 then 1.
- Response: second frame accepted one IDLE cycle after the first `frame_done`; `fft_stages` 1 then 2; extra `do_en` pulses do not double-count.
